// File: rtl/mem_sequencer.sv
// Memory-side sequencer for the SAP-2 core: owns MAR/MDR/SP and turns CPU memory strobes
// and loader writes into handshaked single-port SRAM transactions with round-robin sharing.
module mem_sequencer #(
    parameter logic [15:0] SP_INIT = 16'hFFFF
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [7:0]  BUS,
    input  logic [7:0]  CTRL_MEMORY,
    input  logic [15:0] PC_IN,
    output logic [7:0]  MEM_OUT,
    output logic [15:0] RET_PC,
    output logic        RET_VALID,
    output logic        STALL,
    output logic        SRAM_REQ,
    output logic        SRAM_WE,
    output logic [15:0] SRAM_ADDR,
    output logic [7:0]  SRAM_WDATA,
    input  logic        SRAM_ACK,
    input  logic [7:0]  SRAM_RDATA,
    input  logic        LD_REQ,
    input  logic [15:0] LD_ADDR,
    input  logic [7:0]  LD_DATA,
    output logic        LD_GNT
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CPU_RD  = 3'd1,
        S_CPU_WR  = 3'd2,
        S_PUSH_HI = 3'd3,
        S_PUSH_LO = 3'd4,
        S_POP_LO  = 3'd5,
        S_POP_HI  = 3'd6,
        S_LD_WR   = 3'd7
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] mar_q, mar_d;
    logic [7:0]  mdr_q, mdr_d;
    logic [15:0] sp_q, sp_d;
    logic [15:0] pc_q, pc_d;
    logic [7:0]  ret_lo_q, ret_lo_d;
    logic [15:0] ret_pc_q, ret_pc_d;
    logic        ret_valid_q, ret_valid_d;
    logic        stall_q, stall_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        ld_gnt_q, ld_gnt_d;
    logic        prefer_ld_q, prefer_ld_d;
    logic        pend_q, pend_d;
    state_e      pend_state_q, pend_state_d;
    logic        pend_we_q, pend_we_d;
    logic [15:0] pend_addr_q, pend_addr_d;
    logic [7:0]  pend_wdata_q, pend_wdata_d;

    logic        cpu_op_s;
    state_e      op_state_s;
    logic        op_we_s;
    logic [15:0] op_addr_s;
    logic [7:0]  op_wdata_s;
    logic        ld_req_s;

    // Decode the highest-priority CPU memory op from pre-edge MAR/MDR/SP
    always_comb begin
        cpu_op_s   = 1'b0;
        op_state_s = S_IDLE;
        op_we_s    = 1'b0;
        op_addr_s  = mar_q;
        op_wdata_s = 8'h00;
        if (stall_q) begin
            cpu_op_s = 1'b0;
        end else if (CTRL_MEMORY[0]) begin
            cpu_op_s   = 1'b1;
            op_state_s = S_POP_LO;
            op_addr_s  = sp_q + 16'd1;
        end else if (CTRL_MEMORY[1]) begin
            cpu_op_s   = 1'b1;
            op_state_s = S_PUSH_HI;
            op_we_s    = 1'b1;
            op_addr_s  = sp_q;
            op_wdata_s = PC_IN[15:8];
        end else if (CTRL_MEMORY[4]) begin
            cpu_op_s   = 1'b1;
            op_state_s = S_CPU_WR;
            op_we_s    = 1'b1;
            op_wdata_s = mdr_q;
        end else if (CTRL_MEMORY[3]) begin
            cpu_op_s   = 1'b1;
            op_state_s = S_CPU_RD;
            op_addr_s  = mar_q + 16'd1;
        end else if (CTRL_MEMORY[2]) begin
            cpu_op_s   = 1'b1;
            op_state_s = S_CPU_RD;
        end else begin
            cpu_op_s = 1'b0;
        end
        // A loader still holding LD_REQ during its grant pulse has already been served
        ld_req_s = LD_REQ & ~ld_gnt_q;
    end

    // Next-state, register strobes and SRAM request sequencing
    always_comb begin
        state_d      = state_q;
        mar_d        = mar_q;
        mdr_d        = mdr_q;
        sp_d         = sp_q;
        pc_d         = pc_q;
        ret_lo_d     = ret_lo_q;
        ret_pc_d     = ret_pc_q;
        ret_valid_d  = 1'b0;
        req_d        = req_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        ld_gnt_d     = 1'b0;
        prefer_ld_d  = prefer_ld_q;
        pend_d       = pend_q;
        pend_state_d = pend_state_q;
        pend_we_d    = pend_we_q;
        pend_addr_d  = pend_addr_q;
        pend_wdata_d = pend_wdata_q;

        if (!stall_q) begin
            if (CTRL_MEMORY[7]) mar_d[15:8] = BUS; else mar_d[15:8] = mar_q[15:8];
            if (CTRL_MEMORY[6]) mar_d[7:0]  = BUS; else mar_d[7:0]  = mar_q[7:0];
            if (CTRL_MEMORY[5]) mdr_d       = BUS; else mdr_d       = mdr_q;
            if (cpu_op_s && CTRL_MEMORY[1] && !CTRL_MEMORY[0]) pc_d = PC_IN; else pc_d = pc_q;
        end else begin
            mar_d = mar_q;
        end

        case (state_q)
            S_IDLE: begin
                // The tie pointer only moves on an actual tie so the loser wins the next one
                if (cpu_op_s && ld_req_s && prefer_ld_q) begin
                    state_d      = S_LD_WR;
                    req_d        = 1'b1;
                    we_d         = 1'b1;
                    addr_d       = LD_ADDR;
                    wdata_d      = LD_DATA;
                    prefer_ld_d  = 1'b0;
                    pend_d       = 1'b1;
                    pend_state_d = op_state_s;
                    pend_we_d    = op_we_s;
                    pend_addr_d  = op_addr_s;
                    pend_wdata_d = op_wdata_s;
                end else if (cpu_op_s) begin
                    state_d = op_state_s;
                    req_d   = 1'b1;
                    we_d    = op_we_s;
                    addr_d  = op_addr_s;
                    wdata_d = op_wdata_s;
                    if (ld_req_s) prefer_ld_d = 1'b1; else prefer_ld_d = prefer_ld_q;
                end else if (ld_req_s) begin
                    state_d = S_LD_WR;
                    req_d   = 1'b1;
                    we_d    = 1'b1;
                    addr_d  = LD_ADDR;
                    wdata_d = LD_DATA;
                end else begin
                    req_d = 1'b0;
                end
            end
            S_CPU_RD: begin
                if (SRAM_ACK) begin
                    mdr_d   = SRAM_RDATA;
                    state_d = S_IDLE;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            S_CPU_WR: begin
                if (SRAM_ACK) begin
                    state_d = S_IDLE;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            S_PUSH_HI: begin
                if (SRAM_ACK) begin
                    state_d = S_PUSH_LO;
                    addr_d  = sp_q - 16'd1;
                    wdata_d = pc_q[7:0];
                end else begin
                    state_d = state_q;
                end
            end
            S_PUSH_LO: begin
                if (SRAM_ACK) begin
                    sp_d    = sp_q - 16'd2;
                    state_d = S_IDLE;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            S_POP_LO: begin
                if (SRAM_ACK) begin
                    ret_lo_d = SRAM_RDATA;
                    state_d  = S_POP_HI;
                    addr_d   = sp_q + 16'd2;
                end else begin
                    state_d = state_q;
                end
            end
            S_POP_HI: begin
                if (SRAM_ACK) begin
                    ret_pc_d    = {SRAM_RDATA, ret_lo_q};
                    ret_valid_d = 1'b1;
                    sp_d        = sp_q + 16'd2;
                    state_d     = S_IDLE;
                    req_d       = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            S_LD_WR: begin
                if (SRAM_ACK && pend_q) begin
                    ld_gnt_d = 1'b1;
                    state_d  = pend_state_q;
                    req_d    = 1'b1;
                    we_d     = pend_we_q;
                    addr_d   = pend_addr_q;
                    wdata_d  = pend_wdata_q;
                    pend_d   = 1'b0;
                end else if (SRAM_ACK) begin
                    ld_gnt_d = 1'b1;
                    state_d  = S_IDLE;
                    req_d    = 1'b0;
                    we_d     = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = S_IDLE;
                req_d   = 1'b0;
                pend_d  = 1'b0;
            end
        endcase

        stall_d = (state_d != S_IDLE) | pend_d;
    end

    // State and output registers
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= S_IDLE;
            mar_q        <= 16'h0000;
            mdr_q        <= 8'h00;
            sp_q         <= SP_INIT;
            pc_q         <= 16'h0000;
            ret_lo_q     <= 8'h00;
            ret_pc_q     <= 16'h0000;
            ret_valid_q  <= 1'b0;
            stall_q      <= 1'b0;
            req_q        <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= 16'h0000;
            wdata_q      <= 8'h00;
            ld_gnt_q     <= 1'b0;
            prefer_ld_q  <= 1'b0;
            pend_q       <= 1'b0;
            pend_state_q <= S_IDLE;
            pend_we_q    <= 1'b0;
            pend_addr_q  <= 16'h0000;
            pend_wdata_q <= 8'h00;
        end else begin
            state_q      <= state_d;
            mar_q        <= mar_d;
            mdr_q        <= mdr_d;
            sp_q         <= sp_d;
            pc_q         <= pc_d;
            ret_lo_q     <= ret_lo_d;
            ret_pc_q     <= ret_pc_d;
            ret_valid_q  <= ret_valid_d;
            stall_q      <= stall_d;
            req_q        <= req_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            ld_gnt_q     <= ld_gnt_d;
            prefer_ld_q  <= prefer_ld_d;
            pend_q       <= pend_d;
            pend_state_q <= pend_state_d;
            pend_we_q    <= pend_we_d;
            pend_addr_q  <= pend_addr_d;
            pend_wdata_q <= pend_wdata_d;
        end
    end

    assign MEM_OUT    = mdr_q;
    assign RET_PC     = ret_pc_q;
    assign RET_VALID  = ret_valid_q;
    assign STALL      = stall_q;
    assign SRAM_REQ   = req_q;
    assign SRAM_WE    = we_q;
    assign SRAM_ADDR  = addr_q;
    assign SRAM_WDATA = wdata_q;
    assign LD_GNT     = ld_gnt_q;

endmodule

// File: tb/tb_mem_sequencer.sv
// Directed testbench for mem_sequencer: strobes, call/ret, wrap, arbitration and reset.
module tb_mem_sequencer;

    logic        CLK;
    logic        RST;
    logic [7:0]  BUS;
    logic [7:0]  CTRL_MEMORY;
    logic [15:0] PC_IN;
    logic [7:0]  MEM_OUT;
    logic [15:0] RET_PC;
    logic        RET_VALID;
    logic        STALL;
    logic        SRAM_REQ;
    logic        SRAM_WE;
    logic [15:0] SRAM_ADDR;
    logic [7:0]  SRAM_WDATA;
    logic        SRAM_ACK;
    logic [7:0]  SRAM_RDATA;
    logic        LD_REQ;
    logic [15:0] LD_ADDR;
    logic [7:0]  LD_DATA;
    logic        LD_GNT;

    int n_cmp = 0;
    int n_err = 0;

    mem_sequencer #(.SP_INIT(16'hFFFF)) dut (
        .CLK(CLK), .RST(RST), .BUS(BUS), .CTRL_MEMORY(CTRL_MEMORY), .PC_IN(PC_IN),
        .MEM_OUT(MEM_OUT), .RET_PC(RET_PC), .RET_VALID(RET_VALID), .STALL(STALL),
        .SRAM_REQ(SRAM_REQ), .SRAM_WE(SRAM_WE), .SRAM_ADDR(SRAM_ADDR),
        .SRAM_WDATA(SRAM_WDATA), .SRAM_ACK(SRAM_ACK), .SRAM_RDATA(SRAM_RDATA),
        .LD_REQ(LD_REQ), .LD_ADDR(LD_ADDR), .LD_DATA(LD_DATA), .LD_GNT(LD_GNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic strobe(input logic [7:0] ctrl, input logic [7:0] val);
        CTRL_MEMORY = ctrl;
        BUS = val;
        step();
        CTRL_MEMORY = 8'h00;
    endtask

    task automatic ack(input logic [7:0] rd);
        SRAM_RDATA = rd;
        SRAM_ACK = 1'b1;
        step();
        SRAM_ACK = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b0;
        step();
        step();
        n_cmp++; if (STALL !== 1'b0) begin n_err++; $display("FAIL reset_stall got=%b exp=0", STALL); end
        n_cmp++; if (SRAM_REQ !== 1'b0) begin n_err++; $display("FAIL reset_req got=%b exp=0", SRAM_REQ); end
        n_cmp++; if (MEM_OUT !== 8'h00) begin n_err++; $display("FAIL reset_mem_out got=%h exp=00", MEM_OUT); end
        n_cmp++; if (RET_VALID !== 1'b0 || LD_GNT !== 1'b0) begin n_err++; $display("FAIL reset_pulses got=%b%b exp=00", RET_VALID, LD_GNT); end
        n_cmp++; if (RET_PC !== 16'h0000) begin n_err++; $display("FAIL reset_ret_pc got=%h exp=0000", RET_PC); end
        RST = 1'b1;
        step();
        // MAR resets to 0000: an immediate ram_enl must address 0000
        strobe(8'h04, 8'h00);
        n_cmp++; if (SRAM_ADDR !== 16'h0000 || SRAM_REQ !== 1'b1) begin n_err++; $display("FAIL reset_mar got=%h req=%b exp=0000 req=1", SRAM_ADDR, SRAM_REQ); end
        ack(8'h00);
    endtask

    task automatic test_write_read();
        int stall_cycles;
        strobe(8'h80, 8'h12);
        strobe(8'h40, 8'h34);
        strobe(8'h20, 8'hA5);
        n_cmp++; if (MEM_OUT !== 8'hA5) begin n_err++; $display("FAIL mdr_load got=%h exp=A5", MEM_OUT); end
        stall_cycles = 0;
        strobe(8'h10, 8'h00);
        n_cmp++; if (SRAM_REQ !== 1'b1 || SRAM_WE !== 1'b1 || SRAM_ADDR !== 16'h1234 || SRAM_WDATA !== 8'hA5)
            begin n_err++; $display("FAIL wr_req got=%b%b %h %h exp=11 1234 A5", SRAM_REQ, SRAM_WE, SRAM_ADDR, SRAM_WDATA); end
        if (STALL) stall_cycles++;
        step();
        if (STALL) stall_cycles++;
        step();
        if (STALL) stall_cycles++;
        n_cmp++; if (SRAM_ADDR !== 16'h1234 || SRAM_REQ !== 1'b1) begin n_err++; $display("FAIL wr_hold got=%h %b exp=1234 1", SRAM_ADDR, SRAM_REQ); end
        ack(8'h00);
        if (STALL) stall_cycles++;
        n_cmp++; if (stall_cycles !== 3) begin n_err++; $display("FAIL wr_stall_len got=%0d exp=3", stall_cycles); end
        n_cmp++; if (SRAM_REQ !== 1'b0) begin n_err++; $display("FAIL wr_req_drop got=%b exp=0", SRAM_REQ); end
        strobe(8'h04, 8'h00);
        n_cmp++; if (SRAM_ADDR !== 16'h1234 || SRAM_WE !== 1'b0) begin n_err++; $display("FAIL enl_addr got=%h we=%b exp=1234 we=0", SRAM_ADDR, SRAM_WE); end
        ack(8'h5A);
        n_cmp++; if (MEM_OUT !== 8'h5A || STALL !== 1'b0) begin n_err++; $display("FAIL enl_data got=%h stall=%b exp=5A stall=0", MEM_OUT, STALL); end
        strobe(8'h08, 8'h00);
        n_cmp++; if (SRAM_ADDR !== 16'h1235) begin n_err++; $display("FAIL enh_addr got=%h exp=1235", SRAM_ADDR); end
        ack(8'h3C);
        n_cmp++; if (MEM_OUT !== 8'h3C) begin n_err++; $display("FAIL enh_data got=%h exp=3C", MEM_OUT); end
    endtask

    task automatic test_call_ret();
        PC_IN = 16'hABCD;
        strobe(8'h02, 8'h00);
        PC_IN = 16'h0000;
        n_cmp++; if (SRAM_ADDR !== 16'hFFFF || SRAM_WDATA !== 8'hAB || SRAM_WE !== 1'b1) begin n_err++; $display("FAIL push_hi got=%h %h we=%b exp=FFFF AB 1", SRAM_ADDR, SRAM_WDATA, SRAM_WE); end
        ack(8'h00);
        n_cmp++; if (SRAM_REQ !== 1'b1 || SRAM_ADDR !== 16'hFFFE || SRAM_WDATA !== 8'hCD || STALL !== 1'b1)
            begin n_err++; $display("FAIL push_lo got=%b %h %h stall=%b exp=1 FFFE CD 1", SRAM_REQ, SRAM_ADDR, SRAM_WDATA, STALL); end
        step();
        ack(8'h00);
        n_cmp++; if (SRAM_REQ !== 1'b0 || STALL !== 1'b0) begin n_err++; $display("FAIL push_done got=%b %b exp=0 0", SRAM_REQ, STALL); end
        strobe(8'h01, 8'h00);
        n_cmp++; if (SRAM_ADDR !== 16'hFFFE || SRAM_WE !== 1'b0) begin n_err++; $display("FAIL pop_lo got=%h we=%b exp=FFFE 0", SRAM_ADDR, SRAM_WE); end
        ack(8'hCD);
        n_cmp++; if (SRAM_ADDR !== 16'hFFFF || RET_VALID !== 1'b0) begin n_err++; $display("FAIL pop_hi got=%h rv=%b exp=FFFF 0", SRAM_ADDR, RET_VALID); end
        ack(8'hAB);
        n_cmp++; if (RET_PC !== 16'hABCD || RET_VALID !== 1'b1 || STALL !== 1'b0)
            begin n_err++; $display("FAIL ret_done got=%h rv=%b stall=%b exp=ABCD 1 0", RET_PC, RET_VALID, STALL); end
        step();
        n_cmp++; if (RET_VALID !== 1'b0) begin n_err++; $display("FAIL ret_pulse got=%b exp=0", RET_VALID); end
    endtask

    task automatic test_wrap();
        strobe(8'h01, 8'h00);
        n_cmp++; if (SRAM_ADDR !== 16'h0000) begin n_err++; $display("FAIL wrap_pop_lo got=%h exp=0000", SRAM_ADDR); end
        ack(8'h11);
        n_cmp++; if (SRAM_ADDR !== 16'h0001) begin n_err++; $display("FAIL wrap_pop_hi got=%h exp=0001", SRAM_ADDR); end
        ack(8'h22);
        n_cmp++; if (RET_PC !== 16'h2211) begin n_err++; $display("FAIL wrap_ret_pc got=%h exp=2211", RET_PC); end
        PC_IN = 16'h1357;
        strobe(8'h02, 8'h00);
        n_cmp++; if (SRAM_ADDR !== 16'h0001 || SRAM_WDATA !== 8'h13) begin n_err++; $display("FAIL wrap_push_hi got=%h %h exp=0001 13", SRAM_ADDR, SRAM_WDATA); end
        ack(8'h00);
        n_cmp++; if (SRAM_ADDR !== 16'h0000 || SRAM_WDATA !== 8'h57) begin n_err++; $display("FAIL wrap_push_lo got=%h %h exp=0000 57", SRAM_ADDR, SRAM_WDATA); end
        ack(8'h00);
        strobe(8'h01, 8'h00);
        n_cmp++; if (SRAM_ADDR !== 16'h0000) begin n_err++; $display("FAIL wrap_sp got=%h exp=0000", SRAM_ADDR); end
        ack(8'h00);
        ack(8'h00);
        strobe(8'h80, 8'hFF);
        strobe(8'h40, 8'hFF);
        strobe(8'h08, 8'h00);
        n_cmp++; if (SRAM_ADDR !== 16'h0000) begin n_err++; $display("FAIL wrap_enh got=%h exp=0000", SRAM_ADDR); end
        ack(8'h00);
    endtask

    task automatic test_arbitration();
        RST = 1'b0;
        step();
        RST = 1'b1;
        step();
        strobe(8'h80, 8'h00);
        strobe(8'h40, 8'h10);
        strobe(8'h20, 8'h99);
        LD_REQ = 1'b1; LD_ADDR = 16'h0040; LD_DATA = 8'h77;
        strobe(8'h10, 8'h00);
        n_cmp++; if (SRAM_ADDR !== 16'h0010 || SRAM_WDATA !== 8'h99 || STALL !== 1'b1)
            begin n_err++; $display("FAIL tie1_cpu got=%h %h stall=%b exp=0010 99 1", SRAM_ADDR, SRAM_WDATA, STALL); end
        ack(8'h00);
        step();
        n_cmp++; if (SRAM_REQ !== 1'b1 || SRAM_ADDR !== 16'h0040 || SRAM_WDATA !== 8'h77 || SRAM_WE !== 1'b1)
            begin n_err++; $display("FAIL tie1_ld got=%b %h %h we=%b exp=1 0040 77 1", SRAM_REQ, SRAM_ADDR, SRAM_WDATA, SRAM_WE); end
        ack(8'h00);
        LD_REQ = 1'b0;
        n_cmp++; if (LD_GNT !== 1'b1 || SRAM_REQ !== 1'b0 || STALL !== 1'b0)
            begin n_err++; $display("FAIL tie1_gnt got=%b req=%b stall=%b exp=1 0 0", LD_GNT, SRAM_REQ, STALL); end
        step();
        n_cmp++; if (LD_GNT !== 1'b0) begin n_err++; $display("FAIL gnt_pulse got=%b exp=0", LD_GNT); end
        LD_REQ = 1'b1; LD_ADDR = 16'h0041; LD_DATA = 8'h88;
        strobe(8'h04, 8'h00);
        n_cmp++; if (SRAM_ADDR !== 16'h0041 || SRAM_WDATA !== 8'h88 || STALL !== 1'b1)
            begin n_err++; $display("FAIL tie2_ld got=%h %h stall=%b exp=0041 88 1", SRAM_ADDR, SRAM_WDATA, STALL); end
        ack(8'h00);
        LD_REQ = 1'b0;
        n_cmp++; if (LD_GNT !== 1'b1 || SRAM_REQ !== 1'b1 || SRAM_ADDR !== 16'h0010 || SRAM_WE !== 1'b0 || STALL !== 1'b1)
            begin n_err++; $display("FAIL tie2_pend got=gnt%b req%b %h we%b stall%b exp=gnt1 req1 0010 we0 stall1", LD_GNT, SRAM_REQ, SRAM_ADDR, SRAM_WE, STALL); end
        ack(8'hE7);
        n_cmp++; if (MEM_OUT !== 8'hE7 || STALL !== 1'b0 || LD_GNT !== 1'b0)
            begin n_err++; $display("FAIL tie2_done got=%h stall=%b gnt=%b exp=E7 0 0", MEM_OUT, STALL, LD_GNT); end
    endtask

    task automatic test_reset_mid_push();
        PC_IN = 16'h4321;
        strobe(8'h02, 8'h00);
        ack(8'h00);
        n_cmp++; if (SRAM_ADDR !== 16'hFFFE || SRAM_REQ !== 1'b1) begin n_err++; $display("FAIL midrst_pre got=%h %b exp=FFFE 1", SRAM_ADDR, SRAM_REQ); end
        #2 RST = 1'b0;
        #1;
        n_cmp++; if (SRAM_REQ !== 1'b0 || STALL !== 1'b0) begin n_err++; $display("FAIL midrst_async got=%b %b exp=0 0", SRAM_REQ, STALL); end
        #1 RST = 1'b1;
        ack(8'h00);
        n_cmp++; if (SRAM_REQ !== 1'b0 || STALL !== 1'b0) begin n_err++; $display("FAIL midrst_late_ack got=%b %b exp=0 0", SRAM_REQ, STALL); end
        strobe(8'h02, 8'h00);
        n_cmp++; if (SRAM_ADDR !== 16'hFFFF || SRAM_WDATA !== 8'h43) begin n_err++; $display("FAIL midrst_sp got=%h %h exp=FFFF 43", SRAM_ADDR, SRAM_WDATA); end
        ack(8'h00);
        ack(8'h00);
    endtask

    initial begin
        RST = 1'b0; BUS = 8'h00; CTRL_MEMORY = 8'h00; PC_IN = 16'h0000;
        SRAM_ACK = 1'b0; SRAM_RDATA = 8'h00;
        LD_REQ = 1'b0; LD_ADDR = 16'h0000; LD_DATA = 8'h00;
        test_reset();
        test_write_read();
        test_call_ret();
        test_wrap();
        test_arbitration();
        test_reset_mid_push();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_sequencer.md
# mem_sequencer

Memory-side sequencer for the SAP-2 core. It owns MAR, MDR and the call/return stack pointer, and turns the CPU's memory control strobes into handshaked single-port SRAM transactions, including the two-byte push/pop for CALL/RET. It shares the SRAM between the CPU and an external program loader using round-robin arbitration. It asserts STALL so the integration can gate the CPU clock while an access is in flight.

## Interface
- SP_INIT, 16'hFFFF, stack pointer reset value.
- CLK  in  1  single clock.
- RST  in  1  reset, asynchronous, active-low.
- BUS  in  8  CPU bus value.
- CTRL_MEMORY  in  8  {mar_loadh, mar_loadl, mdr_load, ram_load, ram_enh, ram_enl, call, ret}.
- PC_IN  in  16  return address to push on call.
- MEM_OUT  out  8  current MDR.
- RET_PC  out  16  popped return address.
- RET_VALID  out  1  one-cycle pulse when RET_PC is updated.
- STALL  out  1  registered; high while any access is busy or pending.
- SRAM_REQ  out  1  request, held until ack.
- SRAM_WE  out  1  1 = write.
- SRAM_ADDR  out  16  address.
- SRAM_WDATA  out  8  write data.
- SRAM_ACK  in  1  one-cycle completion pulse.
- SRAM_RDATA  in  8  read data, valid with ack.
- LD_REQ  in  1  loader write request; LD_ADDR and LD_DATA are held until grant.
- LD_ADDR  in  16  loader address.
- LD_DATA  in  8  loader write data.
- LD_GNT  out  1  one-cycle pulse on loader write completion.

## Operation
- **States:** IDLE, CPU_RD, CPU_WR, PUSH_HI, PUSH_LO, POP_LO, POP_HI, LD_WR.
- **Reset values:** MAR=0, MDR=0, SP=SP_INIT, RET_PC=0. All outputs are 0. Round-robin pointer favours the CPU. No op is pending.
- **Register strobes:** sampled only when STALL=0.
  - mar_loadh → MAR[15:8]=BUS.
  - mar_loadl → MAR[7:0]=BUS.
  - mdr_load → MDR=BUS.
  - These apply on the sampling edge regardless of arbitration.
- **Memory ops:** one per sample, priority ret > call > ram_load > ram_enh > ram_enl. Lower-priority strobes in the same cycle are dropped. A memory op uses MAR/MDR values from before any same-edge register load.
  - ram_load → CPU_WR: write MDR to [MAR].
  - ram_enl → CPU_RD: read [MAR] into MDR.
  - ram_enh → CPU_RD: read [MAR+1 mod 2^16] into MDR.
  - call → PUSH_HI then PUSH_LO.
    - PUSH_HI writes PC_IN[15:8] to [SP].
    - PUSH_LO writes PC_IN[7:0] to [SP-1].
    - Then SP -= 2. PC_IN is latched at the sampling edge.
  - ret → POP_LO then POP_HI.
    - POP_LO reads [SP+1] into RET_PC[7:0].
    - POP_HI reads [SP+2] into RET_PC[15:8].
    - Then SP += 2 and RET_VALID pulses.
  - All SP and address arithmetic wraps mod 2^16.
- **Arbitration:** applies in IDLE when a CPU memory op and LD_REQ arrive in the same sample.
  - Tie winner is the side not served last.
  - If the loader wins, the CPU op is latched as pending and runs immediately after LD_WR completes.
  - With no tie, whichever side requests is served.
  - LD_REQ is not sampled while a CPU op is pending.
- **STALL:** STALL = (state != IDLE) | pending. CPU strobes are ignored while STALL=1; the CPU clock is gated by STALL.
- **Reset mid-operation:** RST low forces IDLE asynchronously, drops SRAM_REQ and clears the pending op. A transaction left in flight is discarded, and an ack arriving in IDLE is ignored.

## Timing
- **Sampling edge (edge 0):** state leaves IDLE. SRAM_REQ, SRAM_WE, SRAM_ADDR and SRAM_WDATA are registered and stable from edge 0 until the ack edge.
- **Single-byte ops:** when SRAM_ACK is sampled high at edge N, the op completes at N.
  - Read data lands in MDR at N.
  - State returns to IDLE at N and STALL falls after N.
  - With ack in the first REQ cycle, STALL is high for exactly 1 cycle.
- **Push/pop:**
  - The second byte's REQ asserts the cycle after the first ack; REQ drops for 0 cycles between bytes, and ADDR/WE/WDATA change at the first ack edge.
  - SP updates, RET_PC completes and RET_VALID pulses at the second ack edge.
- **Loader:** LD_GNT pulses the cycle after the LD_WR ack edge, for one cycle. A pending CPU op issues REQ in that same cycle.
- **MEM_OUT:** reflects MDR combinationally from the register.

## Test plan
1. **Reset:** hold RST=0 → SP=FFFF, MAR=0000, MEM_OUT=00, STALL=0, SRAM_REQ=0, RET_VALID=0, LD_GNT=0.
2. **Write then reads:**
   - Load MAR via BUS=12/34, then mdr_load BUS=A5, then ram_load with ack 3 cycles later → REQ WE=1 ADDR=1234 WDATA=A5, STALL high exactly 3 cycles.
   - ram_enl with RDATA=5A → MEM_OUT=5A.
   - ram_enh → ADDR=1235.
3. **Call/ret:**
   - call, PC_IN=ABCD → writes AB@FFFF then CD@FFFE, SP=FFFD.
   - ret with RDATA CD then AB → reads FFFE then FFFF, RET_PC=ABCD, one RET_VALID pulse, SP=FFFF.
4. **Wrap:**
   - SP=0001, call → writes @0001 then @0000, SP=FFFF.
   - MAR=FFFF, ram_enh → ADDR=0000.
5. **Arbitration:**
   - After reset, LD_REQ (addr 0040, data 77) ties with ram_load → CPU served first, then LD_WR, LD_GNT pulses.
   - Next tie → loader first, CPU op pending, STALL stays high across both transactions.
6. **Reset mid-push:** RST low between the PUSH_HI ack and the PUSH_LO ack → REQ=0, STALL=0, SP=FFFF; a late ack is ignored.
